// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and the baud divisor helper.
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK_WAIT} rx_state_e;
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + baud * os / 2) / (baud * os);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divide-by-DIV tick generator with synchronous restart.
module uart_baud_tick #(
  parameter int DIV = 7
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (restart || cnt == W'(DIV - 1)) ? '0 : cnt + 1'b1;
  assign tick = !restart && cnt == W'(DIV - 1);
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with one-entry holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam parity_e PMODE = parity_e'(PARITY);
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_bits
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_err_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0) begin : g_err_os
    $error("OVERSAMPLE must be even and >= 8");
  end
  if (DIV < 1) begin : g_err_div
    $error("baud divisor below 1");
  end
  rx_state_e state, state_n;
  logic rx_m, rx_s, rx_d, armed;
  logic tick, start, commit, brk, dec, bit_v, zero_all, fe_now;
  logic s_mid, par_bit, pe_acc, fe_acc;
  logic [TW-1:0] tc;
  logic [3:0] bcnt;
  logic [DATA_BITS-1:0] sh;
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk(clk),
    .reset_n(reset_n),
    .restart(start),
    .tick(tick)
  );
  // The decision lands one tick after mid so both builds share identical timing.
  assign dec = tick && tc == TW'(MID);
`ifdef UART_RX_MAJORITY_EN
  logic s_m1;
  assign bit_v = (s_m1 & s_mid) | (s_m1 & rx_s) | (s_mid & rx_s);
`else
  assign bit_v = s_mid;
`endif
  assign zero_all = ~|sh && !(PMODE != PAR_NONE && par_bit);
  assign fe_now = fe_acc | ~bit_v;
  assign busy = state != S_IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    start = 1'b0;
    commit = 1'b0;
    brk = 1'b0;
    case (state)
      S_IDLE: if (armed && rx_d && !rx_s) begin
        start = 1'b1;
        state_n = S_START;
      end
      S_START: if (dec) state_n = bit_v ? S_IDLE : S_DATA;
      S_DATA: if (dec && bcnt == 4'(DATA_BITS - 1)) state_n = PMODE == PAR_NONE ? S_STOP : S_PAR;
      S_PAR: if (dec) state_n = S_STOP;
      S_STOP: if (dec) begin
        if (bcnt == 4'd0 && !bit_v && zero_all) begin
          commit = 1'b1;
          brk = 1'b1;
          state_n = S_BRK_WAIT;
        end else if (bcnt == 4'(STOP_BITS - 1)) begin
          commit = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_BRK_WAIT: if (rx_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {rx_m, rx_s, rx_d, armed} <= '0;
      {s_mid, par_bit, pe_acc, fe_acc} <= '0;
`ifdef UART_RX_MAJORITY_EN
      s_m1 <= 1'b0;
`endif
      tc <= '0;
      bcnt <= '0;
      sh <= '0;
      rx_data <= '0;
      {rx_valid, parity_err, frame_err, break_det, overrun_err} <= '0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
      armed <= !start && (armed || rx_s);
      tc <= start ? '0 : tick ? (tc == TW'(OVERSAMPLE - 1) ? '0 : tc + 1'b1) : tc;
      if (tick && tc == TW'(MID - 1)) s_mid <= rx_s;
`ifdef UART_RX_MAJORITY_EN
      if (tick && tc == TW'(MID - 2)) s_m1 <= rx_s;
`endif
      if (start) begin
        bcnt <= '0;
        fe_acc <= 1'b0;
        pe_acc <= 1'b0;
        par_bit <= 1'b0;
      end else if (dec && state == S_DATA) begin
        sh <= {bit_v, sh[DATA_BITS-1:1]};
        bcnt <= bcnt == 4'(DATA_BITS - 1) ? '0 : bcnt + 1'b1;
      end else if (dec && state == S_PAR) begin
        par_bit <= bit_v;
        pe_acc <= bit_v != (PMODE == PAR_ODD ? ~^sh : ^sh);
      end else if (dec && state == S_STOP) begin
        bcnt <= bcnt + 1'b1;
        fe_acc <= fe_now;
      end
      overrun_err <= commit && rx_valid && !rx_ready;
      if (commit && (!rx_valid || rx_ready)) begin
        rx_data <= sh;
        parity_err <= pe_acc;
        frame_err <= fe_now;
        break_det <= brk;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of uart_rx_param (8N1 and 8E1 instances on one line).
module tb_uart_rx_param;
  localparam int BIT = 112;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b0;
  logic rx_ready = 1'b1;
  logic rdy_p = 1'b1;
  logic [7:0] rx_data, data_p;
  logic rx_valid, parity_err, frame_err, break_det, overrun_err, busy;
  logic valid_p, pe_p, fe_p, bk_p, ovr_p, busy_p;
  int checks = 0;
  int failures = 0;
  int n_acc = 0, n_ovr = 0, n_rise = 0, n_acc_p = 0;
  int b_acc, b_ovr, b_rise, b_acc_p;
  logic busy_q = 1'b0;
  logic [7:0] c_data = '0, c_data_p = '0;
  logic c_pe = 1'b0, c_fe = 1'b0, c_bk = 1'b0, c_pe_p = 1'b0, c_fe_p = 1'b0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(50000000), .BAUD_RATE(460800), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .break_det(break_det), .overrun_err(overrun_err), .busy(busy)
  );

  uart_rx_param #(.CLK_FREQ(50000000), .BAUD_RATE(460800), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .OVERSAMPLE(16)) u_par (
    .clk(clk), .reset_n(reset_n), .rx(rx), .rx_data(data_p), .rx_valid(valid_p),
    .rx_ready(rdy_p), .parity_err(pe_p), .frame_err(fe_p),
    .break_det(bk_p), .overrun_err(ovr_p), .busy(busy_p)
  );

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      n_acc++;
      c_data = rx_data;
      c_pe = parity_err;
      c_fe = frame_err;
      c_bk = break_det;
    end
    if (valid_p && rdy_p) begin
      n_acc_p++;
      c_data_p = data_p;
      c_pe_p = pe_p;
      c_fe_p = fe_p;
    end
    if (overrun_err) n_ovr++;
    if (busy && !busy_q) n_rise++;
    busy_q = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    clks(BIT);
  endtask

  task automatic send(input logic [7:0] d, input int par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par >= 0) drive_bit(par[0]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  initial begin
    clks(20);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_flags", {parity_err, frame_err, break_det, overrun_err, busy}, 0);
    reset_n = 1'b1;
    clks(300);
    check("low_after_rst_busy", busy, 0);
    check("low_after_rst_words", n_acc, 0);
    rx = 1'b1;
    clks(50);
    // 8N1 0x55
    b_acc = n_acc;
    send(8'h55, -1, 1'b1);
    clks(2 * BIT);
    check("t1_count", n_acc - b_acc, 1);
    check("t1_data", c_data, 8'h55);
    check("t1_flags", {c_pe, c_fe, c_bk}, 3'b000);
    check("t1_busy", busy, 0);
    // even parity instance, wrong parity bit
    b_acc_p = n_acc_p;
    send(8'hA3, 1, 1'b1);
    clks(2 * BIT);
    check("t2_count", n_acc_p - b_acc_p, 1);
    check("t2_data", c_data_p, 8'hA3);
    check("t2_parity_err", c_pe_p, 1);
    check("t2_frame_err", c_fe_p, 0);
    // low stop bit, then clean frame
    b_acc = n_acc;
    send(8'h3C, -1, 1'b0);
    clks(2 * BIT);
    check("t3_data", c_data, 8'h3C);
    check("t3_flags", {c_pe, c_fe, c_bk}, 3'b010);
    send(8'h7E, -1, 1'b1);
    clks(2 * BIT);
    check("t3_clean_data", c_data, 8'h7E);
    check("t3_clean_flags", {c_pe, c_fe, c_bk}, 3'b000);
    check("t3_count", n_acc - b_acc, 2);
    // break
    b_acc = n_acc;
    rx = 1'b0;
    clks(12 * BIT);
    check("t4_count", n_acc - b_acc, 1);
    check("t4_data", c_data, 8'h00);
    check("t4_flags", {c_pe, c_fe, c_bk}, 3'b011);
    check("t4_busy_low", busy, 1);
    rx = 1'b1;
    clks(2 * BIT);
    check("t4_busy_high", busy, 0);
    check("t4_no_second", n_acc - b_acc, 1);
    // overrun
    rx_ready = 1'b0;
    b_acc = n_acc;
    b_ovr = n_ovr;
    send(8'h11, -1, 1'b1);
    clks(2 * BIT);
    send(8'h22, -1, 1'b1);
    clks(2 * BIT);
    check("t5_valid_held", rx_valid, 1);
    check("t5_data_held", rx_data, 8'h11);
    check("t5_overrun", n_ovr - b_ovr, 1);
    check("t5_no_accept", n_acc - b_acc, 0);
    rx_ready = 1'b1;
    clks(1);
    check("t5_valid_drop", rx_valid, 0);
    check("t5_accepted", n_acc - b_acc, 1);
    check("t5_acc_data", c_data, 8'h11);
    // 3-clk glitch on idle line
    b_acc = n_acc;
    b_rise = n_rise;
    rx = 1'b0;
    clks(3);
    rx = 1'b1;
    clks(2 * BIT);
    check("t6_busy_rose", n_rise - b_rise, 1);
    check("t6_busy_end", busy, 0);
    check("t6_no_word", n_acc - b_acc, 0);
`ifdef UART_RX_MAJORITY_EN
    b_acc = n_acc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rx = 1'b1;
        clks(59);
        rx = 1'b0;
        clks(1);
        rx = 1'b1;
        clks(BIT - 60);
      end else drive_bit(((8'h5A >> i) & 8'h01) != 0);
    end
    drive_bit(1'b1);
    clks(2 * BIT);
    check("maj_count", n_acc - b_acc, 1);
    check("maj_data", c_data, 8'h5A);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
